// File: rtl/geofence_hull_ctrl.sv
// Geofence front-end: captures six receiver points, sorts them counter-clockwise around
// point 0 and accumulates the doubled shoelace area through a shared cross-product unit.
`timescale 1ns/1ps
module geofence_hull_ctrl #(
    parameter int CW  = 10,
    parameter int CPW = 23,
    parameter int AW  = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [CW-1:0]  X,
    input  logic [CW-1:0]  Y,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           cp_req,
    output logic [CW:0]    cp_ax,
    output logic [CW:0]    cp_ay,
    output logic [CW:0]    cp_bx,
    output logic [CW:0]    cp_by,
    input  logic           cp_ack,
    input  logic [CPW-1:0] cp_res,
    output logic           valid,
    output logic [17:0]    order,
    output logic [AW-1:0]  area2
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SORT = 3'd2,
        S_AREA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]          px [6];
    logic [CW-1:0]          py [6];
    logic [2:0]             ord [6];
    logic [2:0]             cnt;
    logic [3:0]             step;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_sum;

    logic                   accept;
    logic                   op_done;
    logic                   issue;

    logic [2:0]             j_pos;
    logic [2:0]             j_nxt;
    logic [2:0]             k_nxt;
    logic [2:0]             idx_a;
    logic [2:0]             idx_b;
    logic [CW:0]            xa, ya, xb, yb, x0, y0;
    logic signed [CW:0]     op_ax, op_ay, op_bx, op_by;
    logic [17:0]            ord_pack;

    // Bubble-sort position j for compare number s: passes 1..4, 1..3, 1..2, 1.
    function automatic logic [2:0] sort_pos(input logic [3:0] s);
        case (s)
            4'd0, 4'd4, 4'd7, 4'd9: sort_pos = 3'd1;
            4'd1, 4'd5, 4'd8:       sort_pos = 3'd2;
            4'd2, 4'd6:             sort_pos = 3'd3;
            4'd3:                   sort_pos = 3'd4;
            default:                sort_pos = 3'd1;
        endcase
    endfunction

    function automatic logic signed [AW-1:0] sext_res(input logic [CPW-1:0] r);
        return {{(AW-CPW){r[CPW-1]}}, r};
    endfunction

    assign in_ready = reset && ((state == S_IDLE) || (state == S_LOAD));
    assign accept   = in_valid && in_ready;
    assign op_done  = cp_req && cp_ack;
    assign acc_sum  = acc + sext_res(cp_res);
    assign ord_pack = {ord[5], ord[4], ord[3], ord[2], ord[1], ord[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && (cnt == 3'd5)) begin
                    state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                issue = !cp_req;
                if (op_done && (step == 4'd9)) begin
                    state_nxt = S_AREA;
                end
            end
            S_AREA: begin
                issue = !cp_req;
                if (op_done && (step == 4'd5)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand select: difference vectors about ord[0] while sorting, raw points for area.
    always_comb begin
        j_pos = sort_pos(step);
        j_nxt = j_pos + 3'd1;
        k_nxt = (step[2:0] == 3'd5) ? 3'd0 : step[2:0] + 3'd1;
        if (state == S_SORT) begin
            idx_a = ord[j_pos];
            idx_b = ord[j_nxt];
        end else begin
            idx_a = ord[step[2:0]];
            idx_b = ord[k_nxt];
        end
        xa = {1'b0, px[idx_a]};
        ya = {1'b0, py[idx_a]};
        xb = {1'b0, px[idx_b]};
        yb = {1'b0, py[idx_b]};
        x0 = {1'b0, px[ord[0]]};
        y0 = {1'b0, py[ord[0]]};
        if (state == S_SORT) begin
            op_ax = xa - x0;
            op_ay = ya - y0;
            op_bx = xb - x0;
            op_by = yb - y0;
        end else begin
            op_ax = xa;
            op_ay = ya;
            op_bx = xb;
            op_by = yb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                px[i]  <= '0;
                py[i]  <= '0;
                ord[i] <= '0;
            end
            cnt    <= '0;
            step   <= '0;
            acc    <= '0;
            cp_req <= 1'b0;
            cp_ax  <= '0;
            cp_ay  <= '0;
            cp_bx  <= '0;
            cp_by  <= '0;
            valid  <= 1'b0;
            order  <= '0;
            area2  <= '0;
        end else begin
            valid <= 1'b0;

            if (accept) begin
                px[cnt] <= X;
                py[cnt] <= Y;
                cnt     <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
                if (state == S_IDLE) begin
                    for (int i = 0; i < 6; i++) begin
                        ord[i] <= 3'(i);
                    end
                end
            end

            if (issue) begin
                cp_req <= 1'b1;
                cp_ax  <= op_ax;
                cp_ay  <= op_ay;
                cp_bx  <= op_bx;
                cp_by  <= op_by;
            end

            if (op_done) begin
                cp_req <= 1'b0;
                if (state == S_SORT) begin
                    // Negative cross: ord[j+1] lies clockwise of ord[j]; collinear keeps order.
                    if (cp_res[CPW-1]) begin
                        ord[j_pos] <= ord[j_nxt];
                        ord[j_nxt] <= ord[j_pos];
                    end
                    if (step == 4'd9) begin
                        step <= '0;
                        acc  <= '0;
                    end else begin
                        step <= step + 4'd1;
                    end
                end else if (state == S_AREA) begin
                    acc <= acc_sum;
                    if (step == 4'd5) begin
                        step  <= '0;
                        valid <= 1'b1;
                        order <= ord_pack;
                        area2 <= acc_sum;
                    end else begin
                        step <= step + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_geofence_hull_ctrl.sv
// Directed bench for geofence_hull_ctrl with a behavioural cross-product unit responder.
`timescale 1ns/1ps
module tb_geofence_hull_ctrl;

    localparam int CW  = 10;
    localparam int CPW = 23;
    localparam int AW  = 24;

    // Point indices A..F = 0..5; sequences list arrival order, field i = point sent i-th.
    localparam logic [17:0] SEQ_SCR = {3'd4, 3'd2, 3'd5, 3'd1, 3'd3, 3'd0};
    localparam logic [17:0] SEQ_CCW = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [17:0] SEQ_CW  = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    localparam logic [17:0] ORD_SCR = {3'd3, 3'd5, 3'd1, 3'd4, 3'd2, 3'd0};
    localparam logic [17:0] ORD_CCW = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [17:0] ORD_CW  = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    localparam logic [AW-1:0] AREA_HEX = 24'd52200;

    logic           clk;
    logic           reset;
    logic [CW-1:0]  X, Y;
    logic           in_valid;
    logic           in_ready;
    logic           cp_req;
    logic [CW:0]    cp_ax, cp_ay, cp_bx, cp_by;
    logic           cp_ack;
    logic [CPW-1:0] cp_res;
    logic           valid;
    logic [17:0]    order;
    logic [AW-1:0]  area2;

    logic           ack_r;
    logic           stray_ack;
    assign cp_ack = ack_r | stray_ack;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int req_rises = 0;
    int ack_cnt = 0;
    int stab_err = 0;
    int junk_bad = 0;
    bit rand_lat = 1'b0;
    logic [CW-1:0] ptx [6];
    logic [CW-1:0] pty [6];

    geofence_hull_ctrl #(.CW(CW), .CPW(CPW), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .X        (X),
        .Y        (Y),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cp_req   (cp_req),
        .cp_ax    (cp_ax),
        .cp_ay    (cp_ay),
        .cp_bx    (cp_bx),
        .cp_by    (cp_by),
        .cp_ack   (cp_ack),
        .cp_res   (cp_res),
        .valid    (valid),
        .order    (order),
        .area2    (area2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Cross-product unit: acks a request after lat negedges, computes ax*by - ay*bx.
    initial begin : responder
        int lat, waitc, ax, ay, bx, by, r;
        bit prev_req;
        logic [4*(CW+1)-1:0] held;
        ack_r = 1'b0;
        cp_res = '0;
        lat = 1;
        waitc = 0;
        prev_req = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                ack_r = 1'b0;
                waitc = 0;
                prev_req = 1'b0;
            end else begin
                if (ack_r) begin
                    ack_r = 1'b0;
                    waitc = 0;
                end else if (cp_req) begin
                    if (!prev_req) begin
                        req_rises++;
                        held = {cp_ax, cp_ay, cp_bx, cp_by};
                        lat = rand_lat ? int'($urandom_range(5, 1)) : 1;
                        waitc = 0;
                    end else if ({cp_ax, cp_ay, cp_bx, cp_by} !== held) begin
                        stab_err++;
                    end
                    waitc++;
                    if (waitc >= lat) begin
                        ax = int'($signed(cp_ax));
                        ay = int'($signed(cp_ay));
                        bx = int'($signed(cp_bx));
                        by = int'($signed(cp_by));
                        r = ax * by - ay * bx;
                        cp_res = r[CPW-1:0];
                        ack_r = 1'b1;
                        ack_cnt++;
                    end
                end else if (prev_req) begin
                    stab_err++;
                end
                prev_req = cp_req;
            end
        end
    end

    task automatic send_obj(input logic [17:0] seq, input bit junk);
        int g;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            X = ptx[seq[3*i +: 3]];
            Y = pty[seq[3*i +: 3]];
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            end
            @(posedge clk);
        end
        #1 acc_cyc = cyc;
        @(negedge clk);
        if (junk) begin
            X = 10'd1023;
            Y = 10'd7;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(input bit junk, output logic [17:0] o,
                               output logic [AW-1:0] a, output int lat);
        int g;
        bit seen;
        g = 0;
        seen = 1'b0;
        o = '0;
        a = '0;
        lat = 0;
        while (!seen && g < 400) begin
            @(negedge clk);
            if (junk && in_ready) junk_bad++;
            if (valid) begin
                seen = 1'b1;
                o = order;
                a = area2;
                lat = cyc - acc_cyc + 1;
            end
            g++;
        end
        if (junk) in_valid = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL valid_timeout: valid=%0b required 1 within 400 cycles", valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
        n_cmp++;
        if (cp_req !== 1'b0) begin n_bad++; $display("FAIL rst_cp_req: got %0b required 0", cp_req); end
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b required 0", valid); end
        n_cmp++;
        if (order !== 18'd0 || area2 !== '0) begin
            n_bad++; $display("FAIL rst_outputs: order=%h area2=%0d required 0/0", order, area2);
        end
        n_cmp++;
        if ({cp_ax, cp_ay, cp_bx, cp_by} !== '0) begin
            n_bad++; $display("FAIL rst_operands: got %h required 0", {cp_ax, cp_ay, cp_bx, cp_by});
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_scrambled();
        logic [17:0] o; logic [AW-1:0] a; int lat;
        send_obj(SEQ_SCR, 1'b0);
        wait_result(1'b0, o, a, lat);
        n_cmp++;
        if (o !== ORD_SCR) begin n_bad++; $display("FAIL scr_order: got %h required %h", o, ORD_SCR); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL scr_area2: got %0d required %0d", a, AREA_HEX); end
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL scr_valid_pulse: got %0b required 0", valid); end
    endtask

    task automatic test_ccw_latency();
        logic [17:0] o; logic [AW-1:0] a; int lat; int r0;
        r0 = req_rises;
        send_obj(SEQ_CCW, 1'b0);
        wait_result(1'b0, o, a, lat);
        n_cmp++;
        if (o !== ORD_CCW) begin n_bad++; $display("FAIL ccw_order: got %h required %h", o, ORD_CCW); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL ccw_area2: got %0d required %0d", a, AREA_HEX); end
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL ccw_latency: got %0d required 33", lat); end
        n_cmp++;
        if (req_rises - r0 !== 16) begin
            n_bad++; $display("FAIL ccw_req_count: got %0d required 16", req_rises - r0);
        end
    endtask

    task automatic test_cw();
        logic [17:0] o; logic [AW-1:0] a; int lat;
        send_obj(SEQ_CW, 1'b0);
        wait_result(1'b0, o, a, lat);
        n_cmp++;
        if (o !== ORD_CW) begin n_bad++; $display("FAIL cw_order: got %h required %h", o, ORD_CW); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL cw_area2: got %0d required %0d", a, AREA_HEX); end
    endtask

    task automatic test_random_ack();
        logic [17:0] o; logic [AW-1:0] a; int lat; int extra;
        stab_err = 0;
        rand_lat = 1'b1;
        send_obj(SEQ_SCR, 1'b0);
        wait_result(1'b0, o, a, lat);
        rand_lat = 1'b0;
        n_cmp++;
        if (stab_err !== 0) begin n_bad++; $display("FAIL rnd_stability: got %0d changes required 0", stab_err); end
        n_cmp++;
        if (o !== ORD_SCR) begin n_bad++; $display("FAIL rnd_order: got %h required %h", o, ORD_SCR); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL rnd_area2: got %0d required %0d", a, AREA_HEX); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin n_bad++; $display("FAIL rnd_single_pulse: got %0d extra pulses required 0", extra); end
    endtask

    task automatic test_reset_mid_sort();
        logic [17:0] o; logic [AW-1:0] a; int lat; int base; int g;
        base = ack_cnt;
        send_obj(SEQ_SCR, 1'b0);
        g = 0;
        while ((ack_cnt < base + 3 || cp_req !== 1'b1) && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (cp_req !== 1'b1) begin n_bad++; $display("FAIL mid_req_before_reset: got %0b required 1", cp_req); end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (cp_req !== 1'b0) begin n_bad++; $display("FAIL mid_cp_req: got %0b required 0", cp_req); end
        n_cmp++;
        if (valid !== 1'b0 || order !== 18'd0 || area2 !== '0) begin
            n_bad++; $display("FAIL mid_outputs: valid=%0b order=%h area2=%0d required 0/0/0", valid, order, area2);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready: got %0b required 0", in_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || cp_req !== 1'b0) begin
            n_bad++; $display("FAIL mid_after_release: in_ready=%0b cp_req=%0b required 1/0", in_ready, cp_req);
        end
        send_obj(SEQ_CW, 1'b0);
        wait_result(1'b0, o, a, lat);
        n_cmp++;
        if (o !== ORD_CW) begin n_bad++; $display("FAIL mid_order: got %h required %h", o, ORD_CW); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL mid_area2: got %0d required %0d", a, AREA_HEX); end
    endtask

    task automatic test_junk_back_to_back();
        logic [17:0] o; logic [AW-1:0] a; int lat;
        junk_bad = 0;
        send_obj(SEQ_SCR, 1'b1);
        wait_result(1'b1, o, a, lat);
        n_cmp++;
        if (junk_bad !== 0) begin n_bad++; $display("FAIL junk_in_ready: got %0d ready cycles required 0", junk_bad); end
        n_cmp++;
        if (o !== ORD_SCR) begin n_bad++; $display("FAIL junk_order: got %h required %h", o, ORD_SCR); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL junk_area2: got %0d required %0d", a, AREA_HEX); end
        send_obj(SEQ_CCW, 1'b0);
        wait_result(1'b0, o, a, lat);
        n_cmp++;
        if (o !== ORD_CCW) begin n_bad++; $display("FAIL b2b_order: got %h required %h", o, ORD_CCW); end
        n_cmp++;
        if (a !== AREA_HEX) begin n_bad++; $display("FAIL b2b_area2: got %0d required %0d", a, AREA_HEX); end
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL b2b_latency: got %0d required 33", lat); end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        X = '0;
        Y = '0;
        stray_ack = 1'b0;
        ptx = '{10'd600, 10'd550, 10'd450, 10'd400, 10'd450, 10'd550};
        pty = '{10'd500, 10'd587, 10'd587, 10'd500, 10'd413, 10'd413};
        test_reset();
        test_scrambled();
        test_ccw_latency();
        test_cw();
        test_random_ack();
        test_reset_mid_sort();
        test_junk_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/geofence_hull_ctrl.md
Name: geofence_hull_ctrl

Overview:
- Front-end sequencer for the geofence datapath. It captures the six receiver coordinates of one object and orders them counter-clockwise around receiver 0, then computes the doubled hexagon area with the shoelace formula.
- It owns no multiplier. Every product goes through a shared external cross-product unit over a req/ack handshake.
- Its outputs (vertex order and doubled area) feed the downstream inside/outside comparator.

Parameters:
- CW, 10: coordinate width, unsigned.
- CPW, 23: signed width of cross-product unit result (2*CW+3).
- AW, 24: signed width of area accumulator.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; low = block in reset.
- X  in  CW  receiver x coordinate.
- Y  in  CW  receiver y coordinate.
- in_valid  in  1  X/Y valid this cycle.
- in_ready  out  1  controller can accept a sample.
- cp_req  out  1  cross-product request.
- cp_ax, cp_ay, cp_bx, cp_by  out  CW+1 each  signed operands; unit returns ax*by - ay*bx.
- cp_ack  in  1  result valid, one-cycle pulse.
- cp_res  in  CPW  signed result, sampled when cp_ack=1.
- valid  out  1  one-cycle pulse: order/area2 updated.
- order  out  18  field k (bits 3k+2:3k) = arrival index (0..5) of CCW vertex k.
- area2  out  AW  signed doubled hexagon area.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - valid=0, area2=0, order=0, cp_req=0, all cp operands=0, in_ready forced 0.
  - Point registers and permutation are cleared.
  - Any operation in flight is abandoned and cp_req drops immediately.
  - A cp_ack that arrives after reset release with no request outstanding is ignored.
- States: IDLE, LOAD, SORT, AREA, DONE.
  - in_ready=1 in IDLE/LOAD only.
  - A sample is accepted on a clk edge where in_valid & in_ready.
  - Samples are stored as P[0..5] in arrival order. The permutation is initialised to 0,1,2,3,4,5.
  - IDLE goes to LOAD on the 1st accept. The 6th accept moves the state to SORT.
  - in_valid is ignored outside IDLE/LOAD.
- Handshake:
  - cp_req rises in the cycle after the previous op completes.
  - cp_req and operands stay stable until the cycle cp_ack=1. cp_req drops at that edge.
  - The unit guarantees ack no earlier than 1 cycle after req rises; a combinational ack is illegal.
  - cp_ack while cp_req=0 is ignored.
  - Minimum cost is 2 cycles per op.
- SORT: 10 compares, bubble order, on permutation positions (j, j+1).
  - Sequence: j=1,2,3,4 / 1,2,3 / 1,2 / 1.
  - Operands: a = P[ord[j]]-P[ord[0]], b = P[ord[j+1]]-P[ord[0]], as signed CW+1.
  - If cp_res < 0, swap ord[j] and ord[j+1] at the ack edge.
  - If cp_res = 0 (collinear), no swap.
  - Position 0 is never moved.
- AREA: 6 ops, k=0..5.
  - Operands: a = P[ord[k]], b = P[ord[(k+1) mod 6]], raw coordinates zero-extended.
  - The accumulator (cleared on entering AREA) adds sign-extended cp_res at each ack.
  - After the 6th ack the state goes to DONE.
- DONE (1 cycle):
  - valid=1; order and area2 are registered from the permutation and accumulator.
  - The next state is IDLE.
  - order/area2 hold their values until the next DONE.
- Latency with 1-cycle ack: valid is high in the 33rd cycle after the 6th-accept edge.
- Widths:
  - Difference vectors fit CW+1 signed.
  - |cross| ≤ 2*1023² < 2^22, so no overflow in CPW.
  - The area sum of 6 terms fits AW.
  - No saturation logic.
- Degenerate input (duplicate points): the fixed sequence still runs to completion. order is a valid permutation and area2 is whatever the arithmetic yields.

Test Plan:
- Scrambled hexagon: input A(600,500), D(400,500), B(550,587), F(550,413), C(450,587), E(450,413) -> one valid pulse, order fields 0,2,4,1,5,3 (k=0..5), area2=52200.
- Already CCW input A,B,C,D,E,F with 1-cycle ack -> zero swaps, order 0,1,2,3,4,5, area2=52200, valid exactly 33 cycles after 6th accept, exactly 16 cp_req rises.
- Clockwise input A,F,E,D,C,B -> order 0,5,4,3,2,1, area2=52200 (positive).
- Random ack latency 1–5 cycles on test 1 -> cp_req/operands never change while waiting, same order/area2, one valid pulse.
- Reset pulled low mid-SORT (after 3 acks) -> cp_req, valid, order, area2 go to 0 asynchronously. After release in_ready=1, and a full new object gives the correct result.
- in_valid held high during SORT/AREA/DONE with junk X/Y -> in_ready=0, junk not captured. Back-to-back objects (next sample the cycle after DONE) -> both results correct.
